// File: rtl/release_pkg.sv
// Shared types and defaults for the release coordinator.
// Encodes the controller states and the default serial-number width.
package release_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } rc_state_t;

    localparam int unsigned SN_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/lane_hit_encoder.sv
// Classifies the per-lane "next is stored" claims.
// The outputs are: any claim, more than one claim, and the claim vector when it is one-hot.
module lane_hit_encoder #(
    parameter int unsigned NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0] hits,
    output logic                 any_hit,
    output logic                 multi_hit,
    output logic [NUM_LANES-1:0] onehot
);

    logic seen;

    always_comb begin
        any_hit   = |hits;
        multi_hit = 1'b0;
        seen      = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (hits[i]) begin
                if (seen) begin
                    multi_hit = 1'b1;
                end
                seen = 1'b1;
            end
        end
        onehot = multi_hit ? '0 : hits;
    end

endmodule

// File: rtl/release_coordinator.sv
// In-order release controller. It owns the global `next` serial and pulses release
// to the single lane that holds `next`. It also flags completion, stalls and conflicting claims.
module release_coordinator
    import release_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned SN_WIDTH    = SN_WIDTH_DEFAULT,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [SN_WIDTH-1:0]  total_count,
    input  logic [NUM_LANES-1:0] lane_next_in_storage,
    output logic [NUM_LANES-1:0] lane_release,
    output logic [SN_WIDTH-1:0]  next,
    output logic [SN_WIDTH-1:0]  released_count,
    output logic                 last_processed,
    output logic                 busy,
    output logic                 error,
    output logic                 timeout
);

    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    rc_state_t            state_q, state_d;
    logic [SN_WIDTH-1:0]  next_q, next_d;
    logic [SN_WIDTH-1:0]  count_q, count_d;
    logic [SN_WIDTH-1:0]  limit_q, limit_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 last_q, last_d;
    logic                 error_q, error_d;
    logic                 timeout_q, timeout_d;

    logic                 any_hit;
    logic                 multi_hit;
    logic [NUM_LANES-1:0] onehot;

    lane_hit_encoder #(
        .NUM_LANES(NUM_LANES)
    ) u_hit_enc (
        .hits      (lane_next_in_storage),
        .any_hit   (any_hit),
        .multi_hit (multi_hit),
        .onehot    (onehot)
    );

    always_comb begin
        state_d      = state_q;
        next_d       = next_q;
        count_d      = count_q;
        limit_d      = limit_q;
        stall_d      = stall_q;
        last_d       = last_q;
        error_d      = error_q;
        timeout_d    = timeout_q;
        lane_release = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    limit_d = total_count;
                    next_d  = '0;
                    count_d = '0;
                    stall_d = '0;
                    if (total_count == '0) begin
                        last_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        last_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (multi_hit) begin
                    error_d = 1'b1;
                    state_d = ERROR;
                end else if (any_hit) begin
                    lane_release = onehot;
                    next_d       = next_q + SN_WIDTH'(1);
                    count_d      = count_q + SN_WIDTH'(1);
                    stall_d      = '0;
                    // The check uses next+1 so a limit of 2^SN_WIDTH-1 finishes before `next` wraps.
                    if (next_d == limit_q) begin
                        last_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    if (stall_q != STALL_W'(STALL_LIMIT)) begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                    if (stall_q >= STALL_W'(STALL_LIMIT - 1)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            ERROR: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            next_q    <= '0;
            count_q   <= '0;
            limit_q   <= '0;
            stall_q   <= '0;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            stall_q   <= stall_d;
            last_q    <= last_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    assign next           = next_q;
    assign released_count = count_q;
    assign last_processed = last_q;
    assign busy           = (state_q == RUN);
    assign error          = error_q;
    assign timeout        = timeout_q;

endmodule

// File: doc/release_coordinator.md
Name: release_coordinator

Overview:
- Global in-order release controller driving the release side of N parallel store_and_release lanes; each join lane holds tuples tagged with a global serial number.
- Owns the `next` serial counter. Watches every lane's next_in_storage and pulses release_data to the single lane holding `next`, then advances `next`.
- Signals end-of-stream and watchdog/protocol errors to the top level.

Parameters:
- NUM_LANES, 4, number of store_and_release lanes served
- SN_WIDTH, 32, serial number, `next` and count width
- STALL_LIMIT, 1024, consecutive cycles without a release before the timeout flag sets

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  load total_count and begin releasing from serial 0; honoured in IDLE or DONE only
- total_count  in  SN_WIDTH  number of serials in the stream, sampled on accepted start
- lane_next_in_storage  in  NUM_LANES  per lane: serial `next` is stored and the lane output is ready
- lane_release  out  NUM_LANES  one-hot release_data per lane, combinational
- next  out  SN_WIDTH  serial to release, registered, broadcast to all lanes
- released_count  out  SN_WIDTH  releases since start, registered
- last_processed  out  1  all serials released; drives lanes' in_last_processed, registered
- busy  out  1  state is RUN
- error  out  1  sticky: more than one lane claimed `next`
- timeout  out  1  sticky: STALL_LIMIT cycles in RUN without a release

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; next=0, released_count=0, last_processed=0, error=0, timeout=0, stall counter=0.
  - lane_release forced to 0 immediately, because it is gated by state==RUN.
- States: IDLE, RUN, DONE, ERROR.
- IDLE:
  - start=1 loads total_count into the limit register and sets next=0, released_count=0, last_processed=0, stall counter=0.
  - Goes to RUN, or to DONE if total_count==0.
- RUN, each cycle, with hits = lane_next_in_storage:
  - Exactly one bit set: lane_release = hits in the same cycle. At the edge: next+1, released_count+1, stall counter=0.
  - Zero bits set: lane_release=0 and the stall counter increments. When it reaches STALL_LIMIT, timeout sets (sticky); the counter saturates and the state stays RUN.
  - Two or more bits set: lane_release=0, error=1, go to ERROR. next is not advanced.
  - Release at next == limit-1: the edge sets next=limit, last_processed=1 and goes to DONE.
  - start is ignored.
- Throughput: one release per cycle. A lane invalidates the released slot at the same edge, so it deasserts next_in_storage for the old serial by the next cycle.
- DONE:
  - last_processed=1 and lane_release=0.
  - start re-arms exactly as from IDLE; last_processed clears on that edge.
- ERROR:
  - Terminal. lane_release=0 and all registers hold.
  - Exit only via reset.
- Widths:
  - next and released_count wrap modulo 2^SN_WIDTH. total_count up to 2^SN_WIDTH-1 is supported.
  - The compare is next+1 == limit on a release, so no wrap occurs before completion.
- Simultaneous start and release: not possible, because start is only honoured outside RUN.
- Lanes compute their local address as next % MAX_NUM. The coordinator imposes no constraint on MAX_NUM.

Decomposition:
- Package release_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} rc_state_t
  - localparam SN_WIDTH_DEFAULT = 32
- One sub-module, lane_hit_encoder, purely combinational and parameterised by NUM_LANES:
  - in: hits
  - out: any_hit, multi_hit (popcount>1), onehot (hits passed through when exactly one bit is set, else 0)

Test Plan:
- NUM_LANES=4, start with total_count=6; hits one-hot lanes 0,1,2,3,0,1 on consecutive cycles -> lane_release mirrors hits in the same cycle; next steps 0..6; released_count=6; last_processed=1 on the edge after the 6th release; state DONE.
- total_count=3; hits=0 for 5 cycles between releases 1 and 2 -> no lane_release during the gap; next holds at 1; stall counter resets on release; timeout stays 0.
- STALL_LIMIT=8, total_count=2; no hits after start -> timeout=1 on the 8th idle cycle. Then assert hits=4'b0010 -> release proceeds; timeout stays 1.
- total_count=4; at next=2, hits=4'b0101 -> lane_release=0; error=1 and ERROR next cycle; next stays 2. Later single hits are ignored until reset.
- start with total_count=0 -> DONE next cycle; last_processed=1; no release ever. Second start with total_count=1 plus a hit on lane 3 -> one release, then back to DONE.
- Mid-RUN (next=3) drop resetn asynchronously between edges -> lane_release=0 immediately; next=0, last_processed=0, state IDLE; start is ignored until resetn=1.
